mvm_seq: RTL and testbench

Parametrised, column-serial signed matrix-vector multiplier with start/busy/done handshake and optional ReLU output stage. It computes `result = f(M · v)` for a `ROWS`×`COLS` matrix. It uses `ROWS` parallel MAC lanes and one matrix column per cycle. It is the compute core for one dense neural-network layer, driven by the layer sequencer.

---
 rtl/mvm_seq.sv | 101 ++++++++++
 tb/tb_mvm_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_seq.sv
// Column-serial signed matrix-vector multiplier: ROWS parallel MAC lanes, one
// matrix column per cycle, optional ReLU applied on write-back.
module mvm_seq #(
  parameter int ROWS      = 6,
  parameter int COLS      = 3,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          relu_en,
  input  logic [ROWS*COLS*WIDTH-1:0]    matrix,
  input  logic [COLS*WIDTH-1:0]         vector,
  output logic [ROWS*ACC_WIDTH-1:0]     result,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  // Handshake: start is sampled only on an edge where busy=0; once accepted,
  // operands are latched and start is ignored until the done cycle, in which
  // the block is already IDLE and may accept the next job.

  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(COLS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]                 state;
  logic [KW-1:0]              k;
  logic [ROWS*COLS*WIDTH-1:0] m_q;
  logic [COLS*WIDTH-1:0]      v_q;
  logic                       relu_q;
  logic signed [ACC_WIDTH-1:0] acc      [ROWS];
  logic signed [ACC_WIDTH-1:0] prod_ext [ROWS];
  int                         k_idx;

  assign k_idx = int'(k);

  // One full-precision signed product per lane for the current column.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic signed [2*WIDTH-1:0] p;
    assign a           = m_q[(r*COLS + k_idx)*WIDTH +: WIDTH];
    assign b           = v_q[k_idx*WIDTH +: WIDTH];
    assign p           = a * b;
    assign prod_ext[r] = ACC_WIDTH'(p);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      k      <= '0;
      m_q    <= '0;
      v_q    <= '0;
      relu_q <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc[r] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q    <= matrix;
            v_q    <= vector;
            relu_q <= relu_en;
            k      <= '0;
            state  <= S_CALC;
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
          end
        end
        S_CALC: begin
          for (int r = 0; r < ROWS; r++) acc[r] <= acc[r] + prod_ext[r];
          // k wraps to 0 on the last column so it never indexes past the operands.
          if (k == K_LAST) begin
            k     <= '0;
            state <= S_WB;
          end else begin
            k <= k + KW'(1);
          end
        end
        S_WB: begin
          for (int r = 0; r < ROWS; r++)
            result[r*ACC_WIDTH +: ACC_WIDTH] <= (relu_q && acc[r][ACC_WIDTH-1]) ? '0 : acc[r];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mvm_seq.sv
// Directed + randomized bench for mvm_seq, checked against an integer-arithmetic
// reference of result = relu(M * v).
module tb_mvm_seq;
  localparam int ROWS  = 6;
  localparam int COLS  = 3;
  localparam int WIDTH = 8;
  localparam int AW    = 20;
  localparam int RW    = ROWS * AW;

  logic                       clk;
  logic                       reset;
  logic                       start;
  logic                       relu_en;
  logic [ROWS*COLS*WIDTH-1:0] matrix;
  logic [COLS*WIDTH-1:0]      vector;
  logic [RW-1:0]              result;
  logic                       busy;
  logic                       done;
  logic [1:0]                 state_dbg;

  mvm_seq #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .matrix(matrix), .vector(vector), .result(result),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m [ROWS][COLS];
  int v [COLS];
  logic [RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] model(input logic relu);
    logic [RW-1:0] out;
    out = '0;
    for (int r = 0; r < ROWS; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < COLS; c++) s += m[r][c] * v[c];
      if (relu && s < 0) s = 0;
      out[r*AW +: AW] = AW'(s);
    end
    return out;
  endfunction

  function automatic logic [RW-1:0] fld(input int val);
    logic [AW-1:0] t;
    t = AW'(val);
    return RW'(t);
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic apply_ops();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) matrix[(r*COLS + c)*WIDTH +: WIDTH] = WIDTH'(m[r][c]);
    for (int c = 0; c < COLS; c++) vector[c*WIDTH +: WIDTH] = WIDTH'(v[c]);
  endtask

  task automatic rand_ops();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < COLS; c++) v[c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic fill_ops(input int mv, input int vv);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = mv;
    for (int c = 0; c < COLS; c++) v[c] = vv;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after E0.
  task automatic start_job(input logic relu);
    apply_ops();
    relu_en = relu;
    start   = 1'b1;
    exp_q.push_back(model(relu));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_job(input string tag);
    int lat, busy_n;
    logic [RW-1:0] exp;
    wait_done(lat, busy_n);
    exp = exp_q.pop_front();
    check({tag, "_latency"}, RW'(lat), RW'(COLS + 1));
    check({tag, "_busy_cycles"}, RW'(busy_n), RW'(COLS + 1));
    check({tag, "_result"}, result, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, RW'(done), RW'(0));
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    start   = 1'b0;
    relu_en = 1'b0;
    matrix  = '0;
    vector  = '0;
    reset   = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("reset_result", result, '0);
    check("reset_busy", RW'(busy), RW'(0));
    check("reset_done", RW'(done), RW'(0));
    #20;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Basic product M[r][k] = r+k, v = (1,2,3).
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = r + c;
    for (int c = 0; c < COLS; c++) v[c] = c + 1;
    start_job(1'b0);
    finish_job("basic");
    check("basic_r0", RW'(result[0 +: AW]), fld(8));
    check("basic_r5", RW'(result[5*AW +: AW]), fld(38));

    // Signed, then the same operands with ReLU.
    rand_ops();
    m[0][0] = -1; m[0][1] = -1; m[0][2] = -1;
    m[1][0] = 2;  m[1][1] = 0;  m[1][2] = 0;
    for (int c = 0; c < COLS; c++) v[c] = 5;
    start_job(1'b0);
    finish_job("signed");
    check("signed_r0", RW'(result[0 +: AW]), fld(-15));
    check("signed_r1", RW'(result[AW +: AW]), fld(10));
    start_job(1'b1);
    finish_job("relu");
    check("relu_r0", RW'(result[0 +: AW]), fld(0));
    check("relu_r1", RW'(result[AW +: AW]), fld(10));

    // Extremes.
    fill_ops(-128, -128);
    start_job(1'b0);
    finish_job("ext_pos");
    check("ext_pos_r3", RW'(result[3*AW +: AW]), fld(49152));
    fill_ops(127, -128);
    start_job(1'b0);
    finish_job("ext_neg");
    check("ext_neg_r2", RW'(result[2*AW +: AW]), fld(-48768));

    // start held high with churning operands; second job taken in the done cycle.
    begin
      int n;
      rand_ops();
      apply_ops();
      relu_en = 1'b0;
      start   = 1'b1;
      exp_q.push_back(model(1'b0));
      @(posedge clk); #1;
      n = 0;
      while (!done && n < 20) begin
        rand_ops();
        apply_ops();
        relu_en = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      check("abuse_latency", RW'(n), RW'(COLS + 1));
      check("abuse_result", result, exp_q.pop_front());
      rand_ops();
      apply_ops();
      relu_en = 1'($urandom_range(0, 1));
      exp_q.push_back(model(relu_en));
      @(posedge clk); #1;
      start = 1'b0;
      finish_job("b2b");
    end

    // Operands change right after acceptance.
    rand_ops();
    start_job(1'b0);
    rand_ops();
    apply_ops();
    relu_en = 1'b1;
    finish_job("latched");

    // Reset during the second CALC cycle.
    rand_ops();
    start_job(1'b0);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("midrst_result", result, '0);
    check("midrst_busy", RW'(busy), RW'(0));
    check("midrst_done", RW'(done), RW'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      repeat (COLS + 3) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      check("midrst_no_done", RW'(seen_done), RW'(0));
      check("midrst_idle", RW'(busy), RW'(0));
    end
    rand_ops();
    start_job(1'b0);
    finish_job("post_rst");

    // Randomized jobs.
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      start_job(1'($urandom_range(0, 1)));
      finish_job($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
